// File: rtl/integ_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | integ_pkg                                                          |
// | Shared phase encoding and default widths for the dual-slope        |
// | integrator model.                                                  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package integ_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_CNT_W = 12;

  typedef enum logic [1:0] {
    FASE_IDLE  = 2'b00,
    FASE_INTEG = 2'b01,
    FASE_DEINT = 2'b10,
    FASE_HOLD  = 2'b11
  } fase_e;

endpackage : integ_pkg
`default_nettype wire

// File: rtl/acum_sat.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | acum_sat                                                           |
// | Unsigned accumulator step: saturating add, or subtract that floors |
// | at zero. Flags saturation on add and floor hit on subtract.        |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module acum_sat #(
  parameter int ACC_W = 16,
  parameter int B_W   = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [B_W-1:0]   b,
  input  logic             sub,
  output logic [ACC_W-1:0] y,
  output logic             ovf,
  output logic             zero
);

  logic [ACC_W-1:0] b_ext;
  logic [ACC_W:0]   sum_w;

  // Compute next accumulator value; a subtract that would reach or cross zero lands on zero
  always_comb begin
    b_ext = {{(ACC_W-B_W){1'b0}}, b};
    sum_w = {1'b0, a} + {1'b0, b_ext};
    y     = a;
    ovf   = 1'b0;
    zero  = 1'b0;
    if (sub) begin
      if (a > b_ext) begin
        y = a - b_ext;
      end else begin
        y    = '0;
        zero = 1'b1;
      end
    end else begin
      if (sum_w[ACC_W]) begin
        y   = '1;
        ovf = 1'b1;
      end else begin
        y = sum_w[ACC_W-1:0];
      end
    end
  end

endmodule : acum_sat
`default_nettype wire

// File: rtl/integrador_dupla_rampa.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | integrador_dupla_rampa                                             |
// | Cycle-accurate model of a dual-slope integrator and zero           |
// | comparator, driven by the voltmeter controller's switch lines.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module integrador_dupla_rampa
  import integ_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ch_in,
  input  logic             ch_ref,
  input  logic             ch_zr,
  input  logic [W-1:0]     vin,
  input  logic [W-1:0]     vref,
  output logic [ACC_W-1:0] vint,
  output logic             Vint_z,
  output logic [CNT_W-1:0] deint_cnt,
  output logic             ovf,
  output logic             sw_err,
  output logic [1:0]       fase
);

  fase_e            fase_q, fase_d;
  logic [ACC_W-1:0] vint_q, vint_d;
  logic             vint_z_q, vint_z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sw_err_q, sw_err_d;

  logic [ACC_W-1:0] acc_y;
  logic             acc_ovf;
  logic             acc_zero;
  logic [W-1:0]     acc_b;
  logic             acc_sub;

  // Integrating adds vin; every other use of the accumulator de-integrates by vref
  assign acc_sub = ~ch_in;
  assign acc_b   = ch_in ? vin : vref;

  acum_sat #(
    .ACC_W (ACC_W),
    .B_W   (W)
  ) u_acum (
    .a    (vint_q),
    .b    (acc_b),
    .sub  (acc_sub),
    .y    (acc_y),
    .ovf  (acc_ovf),
    .zero (acc_zero)
  );

  // Phase FSM next state: discharge first, then illegal-switch check, then phase action
  always_comb begin
    fase_d   = fase_q;
    vint_d   = vint_q;
    vint_z_d = vint_z_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sw_err_d = sw_err_q;

    if (ch_zr) begin
      fase_d   = FASE_IDLE;
      vint_d   = '0;
      vint_z_d = 1'b0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      sw_err_d = 1'b0;
    end else if (ch_in && ch_ref) begin
      sw_err_d = 1'b1;
    end else begin
      case (fase_q)
        FASE_IDLE: begin
          if (ch_in) begin
            vint_d = {{(ACC_W-W){1'b0}}, vin};
            fase_d = FASE_INTEG;
          end else if (ch_ref) begin
            // No charge stored: comparator already at zero
            vint_z_d = 1'b1;
            fase_d   = FASE_HOLD;
          end
        end
        FASE_INTEG: begin
          if (ch_in) begin
            vint_d = acc_y;
            if (acc_ovf) ovf_d = 1'b1;
          end else if (ch_ref) begin
            // First de-integration step happens on the switching edge
            fase_d = FASE_DEINT;
            vint_d = acc_y;
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (acc_zero) begin
              vint_z_d = 1'b1;
              fase_d   = FASE_HOLD;
            end
          end
        end
        FASE_DEINT: begin
          if (ch_in) begin
            sw_err_d = 1'b1;
          end else if (ch_ref) begin
            vint_d = acc_y;
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (acc_zero) begin
              vint_z_d = 1'b1;
              fase_d   = FASE_HOLD;
            end
          end
        end
        default: begin
          // HOLD: frozen until discharge
        end
      endcase
    end
  end

  // State register with immediate asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fase_q   <= FASE_IDLE;
      vint_q   <= '0;
      vint_z_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sw_err_q <= 1'b0;
    end else begin
      fase_q   <= fase_d;
      vint_q   <= vint_d;
      vint_z_q <= vint_z_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sw_err_q <= sw_err_d;
    end
  end

  assign vint      = vint_q;
  assign Vint_z    = vint_z_q;
  assign deint_cnt = cnt_q;
  assign ovf       = ovf_q;
  assign sw_err    = sw_err_q;
  assign fase      = fase_q;

endmodule : integrador_dupla_rampa
`default_nettype wire

// File: tb/tb_integrador_dupla_rampa.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_integrador_dupla_rampa                                          |
// | Directed self-checking bench for the dual-slope integrator model.  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_integrador_dupla_rampa;

  logic        clk;
  logic        rstn;
  logic        ch_in, ch_ref, ch_zr;
  logic [7:0]  vin, vref;
  logic [15:0] vint;
  logic        Vint_z;
  logic [11:0] deint_cnt;
  logic        ovf, sw_err;
  logic [1:0]  fase;

  int checks = 0;
  int errors = 0;

  integrador_dupla_rampa #(.W(8), .ACC_W(16), .CNT_W(12)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ch_in     (ch_in),
    .ch_ref    (ch_ref),
    .ch_zr     (ch_zr),
    .vin       (vin),
    .vref      (vref),
    .vint      (vint),
    .Vint_z    (Vint_z),
    .deint_cnt (deint_cnt),
    .ovf       (ovf),
    .sw_err    (sw_err),
    .fase      (fase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic i, input logic r, input logic z);
    ch_in  = i;
    ch_ref = r;
    ch_zr  = z;
  endtask

  task automatic discharge();
    set_sw(0, 0, 1);
    step();
    set_sw(0, 0, 0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_sw(0, 0, 0);
    vin  = 8'd0;
    vref = 8'd8;
    #2;
    checks++;
    if (vint !== 16'd0 || Vint_z !== 1'b0 || deint_cnt !== 12'd0 || ovf !== 1'b0 ||
        sw_err !== 1'b0 || fase !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: vint=%0d Vint_z=%b cnt=%0d ovf=%b sw_err=%b fase=%b, required all zero",
               vint, Vint_z, deint_cnt, ovf, sw_err, fase);
    end
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Conversion vin=5 x 8 edges, vref=8; used standalone and after a reset
  task automatic run_basic(input string tag);
    logic [15:0] exp_v [5];
    exp_v[0] = 16'd32; exp_v[1] = 16'd24; exp_v[2] = 16'd16; exp_v[3] = 16'd8; exp_v[4] = 16'd0;
    vin  = 8'd5;
    vref = 8'd8;
    set_sw(1, 0, 0);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (vint !== 16'd40 || fase !== 2'b01 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s_integ: vint=%0d fase=%b ovf=%b, required 40 01 0", tag, vint, fase, ovf);
    end
    set_sw(0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (vint !== exp_v[k] || Vint_z !== (k == 4) || deint_cnt !== 12'(k + 1) ||
          fase !== ((k == 4) ? 2'b11 : 2'b10)) begin
        errors++;
        $display("FAIL %s_deint%0d: vint=%0d Vint_z=%b cnt=%0d fase=%b, required %0d %b %0d %b",
                 tag, k + 1, vint, Vint_z, deint_cnt, fase, exp_v[k], (k == 4), k + 1,
                 (k == 4) ? 2'b11 : 2'b10);
      end
    end
    // HOLD ignores further switching without error
    step();
    set_sw(1, 0, 0);
    step();
    checks++;
    if (vint !== 16'd0 || Vint_z !== 1'b1 || deint_cnt !== 12'd5 || fase !== 2'b11 || sw_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold: vint=%0d Vint_z=%b cnt=%0d fase=%b sw_err=%b, required 0 1 5 11 0",
               tag, vint, Vint_z, deint_cnt, fase, sw_err);
    end
    discharge();
  endtask

  task automatic test_basic();
    run_basic("basic");
  endtask

  task automatic test_residue();
    logic [15:0] exp_v [6];
    exp_v[0] = 16'd33; exp_v[1] = 16'd25; exp_v[2] = 16'd17;
    exp_v[3] = 16'd9;  exp_v[4] = 16'd1;  exp_v[5] = 16'd0;
    vin  = 8'd41;
    vref = 8'd8;
    set_sw(1, 0, 0);
    step();
    set_sw(0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (vint !== exp_v[k] || Vint_z !== (k == 5) || deint_cnt !== 12'(k + 1)) begin
        errors++;
        $display("FAIL residue_deint%0d: vint=%0d Vint_z=%b cnt=%0d, required %0d %b %0d",
                 k + 1, vint, Vint_z, deint_cnt, exp_v[k], (k == 5), k + 1);
      end
    end
    discharge();
    checks++;
    if (vint !== 16'd0 || Vint_z !== 1'b0 || deint_cnt !== 12'd0 || fase !== 2'b00) begin
      errors++;
      $display("FAIL residue_clear: vint=%0d Vint_z=%b cnt=%0d fase=%b, required 0 0 0 00",
               vint, Vint_z, deint_cnt, fase);
    end
  endtask

  task automatic test_overflow();
    vin = 8'd255;
    set_sw(1, 0, 0);
    for (int e = 1; e <= 300; e++) begin
      step();
      if (e == 257) begin
        checks++;
        if (vint !== 16'd65535 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_edge257: vint=%0d ovf=%b, required 65535 0", vint, ovf);
        end
      end
      if (e >= 258 && (e == 258 || e == 300)) begin
        checks++;
        if (vint !== 16'd65535 || ovf !== 1'b1) begin
          errors++;
          $display("FAIL ovf_edge%0d: vint=%0d ovf=%b, required 65535 1", e, vint, ovf);
        end
      end
    end
    discharge();
    checks++;
    if (ovf !== 1'b0 || vint !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b vint=%0d, required 0 0", ovf, vint);
    end
  endtask

  task automatic test_illegal();
    vin  = 8'd20;
    vref = 8'd8;
    set_sw(1, 0, 0);
    step();
    set_sw(1, 1, 0);
    step();
    checks++;
    if (sw_err !== 1'b1 || vint !== 16'd20 || fase !== 2'b01) begin
      errors++;
      $display("FAIL illegal_both: sw_err=%b vint=%0d fase=%b, required 1 20 01", sw_err, vint, fase);
    end
    set_sw(0, 0, 0);
    step();
    step();
    checks++;
    if (sw_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: sw_err=%b, required 1", sw_err);
    end
    discharge();
    checks++;
    if (sw_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: sw_err=%b, required 0", sw_err);
    end
    set_sw(1, 0, 0);
    step();
    set_sw(0, 1, 0);
    step();
    set_sw(1, 0, 0);
    step();
    checks++;
    if (sw_err !== 1'b1 || vint !== 16'd12 || fase !== 2'b10 || deint_cnt !== 12'd1) begin
      errors++;
      $display("FAIL illegal_in_deint: sw_err=%b vint=%0d fase=%b cnt=%0d, required 1 12 10 1",
               sw_err, vint, fase, deint_cnt);
    end
    set_sw(0, 0, 0);
    step();
    step();
    checks++;
    if (sw_err !== 1'b1 || vint !== 16'd12 || deint_cnt !== 12'd1) begin
      errors++;
      $display("FAIL deint_freeze: sw_err=%b vint=%0d cnt=%0d, required 1 12 1", sw_err, vint, deint_cnt);
    end
    discharge();
  endtask

  task automatic test_async_reset();
    vin  = 8'd5;
    vref = 8'd8;
    set_sw(1, 0, 0);
    for (int i = 0; i < 8; i++) step();
    set_sw(0, 1, 0);
    step();
    step();
    // Assert reset while clk is still high, before the next rising edge
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (vint !== 16'd0 || Vint_z !== 1'b0 || deint_cnt !== 12'd0 || ovf !== 1'b0 ||
        sw_err !== 1'b0 || fase !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: vint=%0d Vint_z=%b cnt=%0d ovf=%b sw_err=%b fase=%b, required all zero",
               vint, Vint_z, deint_cnt, ovf, sw_err, fase);
    end
    set_sw(0, 0, 0);
    step();
    rstn = 1'b1;
    step();
    run_basic("recovery");
  endtask

  task automatic test_ref_from_idle();
    vref = 8'd8;
    set_sw(0, 1, 0);
    step();
    checks++;
    if (Vint_z !== 1'b1 || deint_cnt !== 12'd0 || fase !== 2'b11 || vint !== 16'd0) begin
      errors++;
      $display("FAIL ref_idle: Vint_z=%b cnt=%0d fase=%b vint=%0d, required 1 0 11 0",
               Vint_z, deint_cnt, fase, vint);
    end
    discharge();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_residue();
    test_overflow();
    test_illegal();
    test_async_reset();
    test_ref_from_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_integrador_dupla_rampa
`default_nettype wire
